// File: rtl/lockstep_result_checker.sv
// lockstep_result_checker
//   Compares the result streams of two redundant cores. Each side is buffered
//   in its own FIFO so the cores may run at different latencies; whenever both
//   FIFOs hold a word, the two heads are popped together and compared.
//   Reports per-comparison strobes, saturating match/mismatch counters and
//   sticky error flags.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   clear           synchronous soft clear, same effect as reset
//   a_data/a_valid  result word and strobe from core A
//   b_data/b_valid  result word and strobe from core B
//   cmp_valid       one-cycle pulse, a comparison completed
//   cmp_equal       result of that comparison
//   match_count     saturating count of equal comparisons
//   mismatch_count  saturating count of unequal comparisons
//   mismatch_sticky set on first mismatch
//   overflow_sticky set when a word was dropped on a full FIFO
//   timeout_sticky  set when one side waited TIMEOUT cycles for the other
//   a_level/b_level FIFO occupancies
module lockstep_result_checker #(
  parameter int WIDTH   = 512,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           a_data,
  input  logic                       a_valid,
  input  logic [WIDTH-1:0]           b_data,
  input  logic                       b_valid,
  output logic                       cmp_valid,
  output logic                       cmp_equal,
  output logic [CNT_W-1:0]           match_count,
  output logic [CNT_W-1:0]           mismatch_count,
  output logic                       mismatch_sticky,
  output logic                       overflow_sticky,
  output logic                       timeout_sticky,
  output logic [$clog2(DEPTH):0]     a_level,
  output logic [$clog2(DEPTH):0]     b_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];

  logic [AW-1:0]    wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic [AW-1:0]    wr_a_d, rd_a_d, wr_b_d, rd_b_d;
  logic [LW-1:0]    lvl_a_q, lvl_b_q, lvl_a_d, lvl_b_d;
  logic             cmp_valid_q, cmp_valid_d, cmp_equal_q, cmp_equal_d;
  logic [CNT_W-1:0] match_q, match_d, mism_q, mism_d;
  logic             mism_st_q, mism_st_d, ovf_st_q, ovf_st_d, tmo_st_q, tmo_st_d;
  logic [15:0]      skew_q, skew_d;

  logic pop, push_a, push_b, heads_eq, a_empty, b_empty;

  always_comb begin
    a_empty  = (lvl_a_q == '0);
    b_empty  = (lvl_b_q == '0);
    pop      = !a_empty && !b_empty;
    heads_eq = (mem_a_q[rd_a_q] == mem_b_q[rd_b_q]);
    // A full FIFO still accepts a word when its head leaves in the same cycle.
    push_a   = a_valid && ((lvl_a_q != LW'(DEPTH)) || pop);
    push_b   = b_valid && ((lvl_b_q != LW'(DEPTH)) || pop);

    wr_a_d   = push_a ? wr_a_q + AW'(1) : wr_a_q;
    wr_b_d   = push_b ? wr_b_q + AW'(1) : wr_b_q;
    rd_a_d   = pop ? rd_a_q + AW'(1) : rd_a_q;
    rd_b_d   = pop ? rd_b_q + AW'(1) : rd_b_q;
    lvl_a_d  = lvl_a_q + LW'(push_a) - LW'(pop);
    lvl_b_d  = lvl_b_q + LW'(push_b) - LW'(pop);

    cmp_valid_d = pop;
    cmp_equal_d = pop && heads_eq;

    match_d   = match_q;
    mism_d    = mism_q;
    mism_st_d = mism_st_q;
    if (pop) begin
      if (heads_eq) begin
        if (match_q != CNT_MAX) match_d = match_q + CNT_W'(1);
      end else begin
        if (mism_q != CNT_MAX) mism_d = mism_q + CNT_W'(1);
        mism_st_d = 1'b1;
      end
    end

    ovf_st_d = ovf_st_q || (a_valid && !push_a) || (b_valid && !push_b);

    // Without a pop, "not both empty" means exactly one side is waiting.
    if ((a_empty && b_empty) || pop) skew_d = '0;
    else if (skew_q != TMO)          skew_d = skew_q + 16'd1;
    else                             skew_d = skew_q;
    tmo_st_d = tmo_st_q || (skew_d == TMO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_a_q      <= '0;
      rd_a_q      <= '0;
      wr_b_q      <= '0;
      rd_b_q      <= '0;
      lvl_a_q     <= '0;
      lvl_b_q     <= '0;
      cmp_valid_q <= 1'b0;
      cmp_equal_q <= 1'b0;
      match_q     <= '0;
      mism_q      <= '0;
      mism_st_q   <= 1'b0;
      ovf_st_q    <= 1'b0;
      tmo_st_q    <= 1'b0;
      skew_q      <= '0;
    end else begin
      wr_a_q      <= wr_a_d;
      rd_a_q      <= rd_a_d;
      wr_b_q      <= wr_b_d;
      rd_b_q      <= rd_b_d;
      lvl_a_q     <= lvl_a_d;
      lvl_b_q     <= lvl_b_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_equal_q <= cmp_equal_d;
      match_q     <= match_d;
      mism_q      <= mism_d;
      mism_st_q   <= mism_st_d;
      ovf_st_q    <= ovf_st_d;
      tmo_st_q    <= tmo_st_d;
      skew_q      <= skew_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (rst_n && !clear) begin
      if (push_a) mem_a_q[wr_a_q] <= a_data;
      if (push_b) mem_b_q[wr_b_q] <= b_data;
    end
  end

  assign cmp_valid       = cmp_valid_q;
  assign cmp_equal       = cmp_equal_q;
  assign match_count     = match_q;
  assign mismatch_count  = mism_q;
  assign mismatch_sticky = mism_st_q;
  assign overflow_sticky = ovf_st_q;
  assign timeout_sticky  = tmo_st_q;
  assign a_level         = lvl_a_q;
  assign b_level         = lvl_b_q;

endmodule

// File: doc/lockstep_result_checker.md
Name: lockstep_result_checker

Overview:
- Parametrised successor to the fixed, single-cycle `sha3_high_out == sha3_low_out` LED comparator.
- Compares the result streams of two redundant cores (e.g. two hash or cipher instances), each buffered in its own FIFO. The two cores may produce results at different latencies.
- Produces per-result equality strobes, saturating match/mismatch counters and sticky error flags for LEDs or debug.
- Sits between the redundant cores and the top-level status outputs.

Parameters:
- WIDTH, 512, result word width in bits (>=1).
- DEPTH, 4, entries per side FIFO (power of two, >=2).
- CNT_W, 16, match/mismatch counter width.
- TIMEOUT, 1023, skew cycles allowed before timeout_sticky sets (>=1, must fit in 16 bits).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous soft clear, active-high
- a_data  in  WIDTH  result word from core A
- a_valid  in  1  core A result strobe, one word per high cycle
- b_data  in  WIDTH  result word from core B
- b_valid  in  1  core B result strobe
- cmp_valid  out  1  one-cycle pulse: a comparison completed
- cmp_equal  out  1  result of that comparison, valid with cmp_valid
- match_count  out  CNT_W  number of equal comparisons
- mismatch_count  out  CNT_W  number of unequal comparisons
- mismatch_sticky  out  1  set on first mismatch
- overflow_sticky  out  1  set when a word was dropped on a full FIFO
- timeout_sticky  out  1  set when skew exceeded TIMEOUT
- a_level  out  $clog2(DEPTH)+1  FIFO A occupancy
- b_level  out  $clog2(DEPTH)+1  FIFO B occupancy

Behaviour:
- Reset: rst_n low at a rising edge clears all state.
  - All outputs go to 0 and both FIFOs are empty.
  - Other inputs are ignored that cycle.
- clear: identical effect to reset; rst_n has priority but the result is the same. Valids coinciding with clear are discarded.
- No backpressure; the block is a passive monitor.
- Push, side X:
  - X_valid high and (level<DEPTH or a pop of X occurs the same cycle) -> word written, level updated at the edge.
  - X_valid high, level==DEPTH and no pop -> word dropped, overflow_sticky<=1, level unchanged.
- Pop: in any cycle where a_level>0 and b_level>0, both FIFO heads are popped together and compared over all WIDTH bits.
  - cmp_valid<=1 and cmp_equal<=(headA==headB) at that edge; otherwise cmp_valid<=0.
  - Equal -> match_count+1. Unequal -> mismatch_count+1 and mismatch_sticky<=1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: a_valid and b_valid in cycle t -> words stored at end of t -> pop/compare in t+1 -> cmp_valid high in cycle t+2.
- Throughput: one comparison per cycle sustained.
- Simultaneous push and pop on the same side is allowed; net level change = push - pop.
- Ordering: strictly FIFO per side. The k-th A word is always compared with the k-th B word.
- Skew timer (16-bit internal):
  - Increments each cycle exactly one FIFO is non-empty and no pop occurs.
  - Returns to 0 when both FIFOs are empty or a pop occurs.
  - On reaching TIMEOUT: timeout_sticky<=1 and the timer holds at TIMEOUT. FIFOs are not flushed.
- Stickies clear only on rst_n or clear.

Test Plan:
- Reset with both valids held high and rst_n=0 for 3 cycles -> all outputs 0, levels 0. Release rst_n -> first compare pulse 2 cycles after the first valids.
- Lockstep: 8 identical words on both sides, every cycle -> 8 cmp_valid pulses, all cmp_equal=1, match_count=8, mismatch_count=0, levels never exceed 1.
- Skew: B lags A by 3 cycles, 4 words, word 2 of B bit 511 flipped -> cmp_equal pattern 1,1,0,1; match_count=3, mismatch_count=1, mismatch_sticky=1.
- Overflow (DEPTH=4): 6 A words, no B -> a_level=4, overflow_sticky=1. Then 4 B words matching A words 0-3 -> 4 matches, a_level=0.
- Timeout (TIMEOUT=10): one A word, no B -> timeout_sticky=1 exactly 10 cycles after a_level becomes 1. A later B word still compares and pops.
- Saturation and clear (CNT_W=2): 5 matching pairs -> match_count=3. Pulse clear -> counters, stickies and levels 0, and a_valid during the clear cycle is not stored.
